irda_cfg_seq: RTL and testbench
===============================

IRDA_CFG_SEQ -- requirements
Module: irda_cfg_seq

Interface
REQ-001 Parameter CDR_VALUE, default 32'd200000, fast-mode clock divider written to IRDA_F_CDR.
REQ-002 Parameter DL_VALUE, default 8'd2, UART divisor latch LSB value written to UART_REG_DL1.
REQ-003 Parameter ACK_TIMEOUT, default 16, maximum cycles one write waits for acknowledge.
REQ-004 clk  input  1  single clock; all flops on rising edge.
REQ-005 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  one-cycle request to run a configuration sequence.
REQ-007 mir_i  input  1  1 = MIR (fast) sequence, 0 = SIR sequence; sampled with start_i.
REQ-008 tx_i  input  1  1 = configure as transmitter, 0 = as receiver; sampled with start_i.
REQ-009 wbm_adr_o  output  4  Wishbone master address.
REQ-010 wbm_dat_o  output  32  Wishbone master write data; 8-bit values are zero-extended.
REQ-011 wbm_we_o, wbm_stb_o, wbm_cyc_o  output  1 each  Wishbone master controls.
REQ-012 wbm_ack_i  input  1  Wishbone acknowledge from the irda_top slave port.
REQ-013 busy_o  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-014 done_o  output  1  one-cycle pulse on successful completion.
REQ-015 err_o  output  1  sticky timeout flag; cleared by the next accepted start.
REQ-016 step_o  output  3  index of the current write within the sequence.

Function
REQ-017 States SHALL be IDLE, REQ, GAP, DONE, ERR.
REQ-018 In IDLE, start_i SHALL latch mir_i/tx_i, clear step and err_o, and enter REQ; start_i outside IDLE SHALL be ignored.
REQ-019 MASTER value SHALL be {3'b0, m, m, 1'b0, tx, 1'b1}, where m is the latched mir_i for MIR steps and 1 for the first SIR step.
REQ-020 MIR sequence, 4 writes: IRDA_MASTER=MASTER(m=1); IRDA_F_CDR=CDR_VALUE; IRDA_F_FCR=8'h83; IRDA_F_LCR = tx ? 8'h02 : 8'h00.
REQ-021 SIR sequence, 6 writes: IRDA_MASTER=MASTER(m=1); IRDA_F_CDR=CDR_VALUE; IRDA_MASTER=MASTER(m=0); UART_REG_LC=8'h9B; UART_REG_DL1=DL_VALUE; UART_REG_LC=8'h1B.
REQ-022 In REQ, cyc, stb and we SHALL be high, with adr/dat taken from the current step; they SHALL be held stable until ack.
REQ-023 wbm_ack_i high in REQ SHALL deassert cyc/stb/we on the next cycle and enter GAP.
REQ-024 GAP SHALL last exactly one cycle with all strobes low; it SHALL then enter DONE if step is the last step, else increment step and enter REQ.
REQ-025 DONE SHALL assert done_o for one cycle and then return to IDLE.
REQ-026 wbm_ack_i SHALL be ignored outside REQ.
REQ-027 An acknowledge in the same cycle the timeout expires SHALL count as success.
REQ-028 Minimum time per write SHALL be 2 cycles (REQ with immediate ack, then GAP).

Reset
REQ-029 Reset SHALL immediately force IDLE and clear all outputs: strobes 0, adr 0, dat 0, busy 0, done 0, err 0, step 0.
REQ-030 Reset mid-sequence SHALL abort the bus cycle asynchronously, and no partial state SHALL survive.

Configuration
REQ-031 Macro IRDA_CFG_SEQ_TIMEOUT_EN, when defined, SHALL enable a timeout counter per write; ACK_TIMEOUT cycles in REQ without ack SHALL drop the strobes, set err_o, enter ERR for one cycle, and then return to IDLE without done_o.
REQ-032 Without IRDA_CFG_SEQ_TIMEOUT_EN, the counter SHALL be absent, REQ SHALL wait indefinitely, and err_o SHALL be tied 0.

Verification
REQ-033 MIR tx: start_i with mir=1, tx=1 and an immediate-ack slave -> writes (MASTER, 0x1B), (F_CDR, 200000), (F_FCR, 0x83), (F_LCR, 0x02) in order, each 2 cycles; done_o pulses once; busy_o is low afterwards.
REQ-034 SIR rx: start_i with mir=0, tx=0 -> 6 writes: 0x19, 200000, 0x01, 0x9B, 0x02, 0x1B; step_o counts 0..5.
REQ-035 Slave acks after 3 wait cycles -> adr/dat/we remain stable during the wait; no duplicate write occurs.
REQ-036 Timeout with the macro enabled: slave never acks at step 2 -> strobes drop after 16 cycles, err_o=1, no done_o; the next start clears err_o and the sequence completes.
REQ-037 start_i pulsed during busy, and wb_rst_i asserted at step 3 -> the start is ignored; reset drops cyc/stb in the same cycle and all outputs read 0.

Source files
------------

// File: rtl/irda_cfg_seq.sv
// irda_cfg_seq
// Wishbone master that programs an irda_top core with a fixed register
// sequence. A start request selects either the MIR (fast) sequence of four
// writes or the SIR sequence of six writes, and chooses transmitter or
// receiver mode. Each write is one Wishbone cycle followed by one idle cycle.
//
// Optional build macro:
//   IRDA_CFG_SEQ_TIMEOUT_EN - adds a per-write acknowledge timeout. On expiry
//   the write is abandoned, err_o is set and the sequence ends without done_o.
//   Without the macro a write waits for its acknowledge indefinitely and
//   err_o is constant 0.
//
// Ports:
//   clk        - single clock, rising edge
//   wb_rst_i   - asynchronous active-high reset
//   start_i    - one-cycle request to run a sequence (honoured only in IDLE)
//   mir_i      - 1 = MIR sequence, 0 = SIR sequence (sampled with start_i)
//   tx_i       - 1 = transmitter, 0 = receiver (sampled with start_i)
//   wbm_adr_o  - Wishbone address (4 bits)
//   wbm_dat_o  - Wishbone write data (8-bit values zero-extended)
//   wbm_we_o, wbm_stb_o, wbm_cyc_o - Wishbone controls
//   wbm_ack_i  - Wishbone acknowledge from the slave
//   busy_o     - sequence in progress
//   done_o     - one-cycle pulse on successful completion
//   err_o      - sticky timeout flag, cleared by the next accepted start
//   step_o     - index of the current write within the sequence

module irda_cfg_seq #(
  parameter logic [31:0] CDR_VALUE   = 32'd200000,
  parameter logic [7:0]  DL_VALUE    = 8'd2,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        mir_i,
  input  logic        tx_i,
  output logic [3:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  step_o
);

  // irda_top register map
  localparam logic [3:0] UART_REG_DL1 = 4'd0;
  localparam logic [3:0] UART_REG_LC  = 4'd3;
  localparam logic [3:0] IRDA_MASTER  = 4'd8;
  localparam logic [3:0] IRDA_F_FCR   = 4'd10;
  localparam logic [3:0] IRDA_F_LCR   = 4'd11;
  localparam logic [3:0] IRDA_F_CDR   = 4'd13;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  step;
  logic        mir_q;
  logic        tx_q;
  logic        timeout_hit;
  logic [2:0]  last_step;
  logic [3:0]  seq_adr;
  logic [31:0] seq_dat;

  // MASTER register image; m selects fast mode bits.
  function automatic logic [31:0] master_val(input logic m, input logic tx);
    return {24'd0, 3'b000, m, m, 1'b0, tx, 1'b1};
  endfunction

  assign last_step = mir_q ? 3'd3 : 3'd5;

  // Register write table indexed by mode and step.
  always_comb begin
    seq_adr = 4'd0;
    seq_dat = 32'd0;
    if (mir_q) begin
      case (step)
        3'd0: begin seq_adr = IRDA_MASTER; seq_dat = master_val(mir_q, tx_q); end
        3'd1: begin seq_adr = IRDA_F_CDR;  seq_dat = CDR_VALUE; end
        3'd2: begin seq_adr = IRDA_F_FCR;  seq_dat = 32'h83; end
        3'd3: begin seq_adr = IRDA_F_LCR;  seq_dat = tx_q ? 32'h02 : 32'h00; end
        default: begin seq_adr = 4'd0; seq_dat = 32'd0; end
      endcase
    end else begin
      // SIR first enables the fast block so the CDR write lands, then
      // switches back to SIR and programs the UART divisor.
      case (step)
        3'd0: begin seq_adr = IRDA_MASTER;  seq_dat = master_val(1'b1, tx_q); end
        3'd1: begin seq_adr = IRDA_F_CDR;   seq_dat = CDR_VALUE; end
        3'd2: begin seq_adr = IRDA_MASTER;  seq_dat = master_val(mir_q, tx_q); end
        3'd3: begin seq_adr = UART_REG_LC;  seq_dat = 32'h9B; end
        3'd4: begin seq_adr = UART_REG_DL1; seq_dat = {24'd0, DL_VALUE}; end
        3'd5: begin seq_adr = UART_REG_LC;  seq_dat = 32'h1B; end
        default: begin seq_adr = 4'd0; seq_dat = 32'd0; end
      endcase
    end
  end

  // Main sequencer. Bus outputs are decoded from the state register so an
  // asynchronous reset drops them immediately.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      step  <= 3'd0;
      mir_q <= 1'b0;
      tx_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            mir_q <= mir_i;
            tx_q  <= tx_i;
            step  <= 3'd0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack arriving in the expiry cycle still wins.
          if (wbm_ack_i) begin
            state <= S_GAP;
          end else if (timeout_hit) begin
            state <= S_ERR;
          end
        end
        S_GAP: begin
          if (step == last_step) begin
            state <= S_DONE;
          end else begin
            step  <= step + 3'd1;
            state <= S_REQ;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IRDA_CFG_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign timeout_hit = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

  // Counts cycles spent in the current REQ; restarts for every write.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= '0;
    end else if (state != S_REQ || wbm_ack_i) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Sticky error, set on the transition into ERR.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && start_i) begin
      err_q <= 1'b0;
    end else if (state == S_REQ && !wbm_ack_i && timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign wbm_cyc_o = (state == S_REQ);
  assign wbm_stb_o = (state == S_REQ);
  assign wbm_we_o  = (state == S_REQ);
  assign wbm_adr_o = (state == S_REQ) ? seq_adr : 4'd0;
  assign wbm_dat_o = (state == S_REQ) ? seq_dat : 32'd0;
  assign busy_o    = (state != S_IDLE);
  assign done_o    = (state == S_DONE);
  assign step_o    = step;

endmodule

// File: tb/tb_irda_cfg_seq.sv
module tb_irda_cfg_seq;

  // Register map of the irda_top slave.
  localparam logic [3:0] A_DL1    = 4'd0;
  localparam logic [3:0] A_LC     = 4'd3;
  localparam logic [3:0] A_MASTER = 4'd8;
  localparam logic [3:0] A_FFCR   = 4'd10;
  localparam logic [3:0] A_FLCR   = 4'd11;
  localparam logic [3:0] A_FCDR   = 4'd13;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        start_i;
  logic        mir_i;
  logic        tx_i;
  logic        wbm_ack_i;
  logic [3:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [2:0]  step_o;

  int total  = 0;
  int passed = 0;

  logic [3:0]  exp_adr[$];
  logic [31:0] exp_dat[$];

  always #5 clk = ~clk;

  irda_cfg_seq dut (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .start_i   (start_i),
    .mir_i     (mir_i),
    .tx_i      (tx_i),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .step_o    (step_o)
  );

  // Reference list of writes the sequence must produce.
  task automatic build_model(input bit mir, input bit tx);
    int mval_fast;
    int mval_slow;
    mval_fast = 1 + 2 * int'(tx) + 24;
    mval_slow = 1 + 2 * int'(tx);
    exp_adr.delete();
    exp_dat.delete();
    exp_adr.push_back(A_MASTER); exp_dat.push_back(32'(mval_fast));
    exp_adr.push_back(A_FCDR);   exp_dat.push_back(32'd200000);
    if (mir) begin
      exp_adr.push_back(A_FFCR); exp_dat.push_back(32'h83);
      exp_adr.push_back(A_FLCR); exp_dat.push_back(tx ? 32'h02 : 32'h00);
    end else begin
      exp_adr.push_back(A_MASTER); exp_dat.push_back(32'(mval_slow));
      exp_adr.push_back(A_LC);     exp_dat.push_back(32'h9B);
      exp_adr.push_back(A_DL1);    exp_dat.push_back(32'h02);
      exp_adr.push_back(A_LC);     exp_dat.push_back(32'h1B);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic kick(input bit mir, input bit tx);
    start_i = 1'b1;
    mir_i   = mir;
    tx_i    = tx;
    @(negedge clk);
    start_i = 1'b0;
    mir_i   = 1'($urandom);
    tx_i    = 1'($urandom);
    total++;
    if ({busy_o, err_o, done_o} !== 3'b100)
      $display("[TB] FAIL kick_state: busy/err/done=%b expected 100", {busy_o, err_o, done_o});
    else passed++;
  endtask

  // Serves one write that is currently presented, acking after lat waits.
  task automatic serve_write(input int idx, input int lat);
    logic [41:0] snap;
    bit          stable;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, step_o, wbm_adr_o, wbm_dat_o} !==
        {3'b111, idx[2:0], exp_adr[idx], exp_dat[idx]})
      $display("[TB] FAIL write_%0d: cyc/stb/we=%b step=%0d adr=%h dat=%h expected 111 step=%0d adr=%h dat=%h",
               idx, {wbm_cyc_o, wbm_stb_o, wbm_we_o}, step_o, wbm_adr_o, wbm_dat_o,
               idx, exp_adr[idx], exp_dat[idx]);
    else passed++;
    snap   = {wbm_cyc_o, wbm_stb_o, wbm_we_o, step_o, wbm_adr_o, wbm_dat_o};
    stable = 1'b1;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, step_o, wbm_adr_o, wbm_dat_o} !== snap)
        stable = 1'b0;
    end
    if (lat > 0) begin
      total++;
      if (stable !== 1'b1)
        $display("[TB] FAIL hold_%0d: bus stable=%b expected 1 over %0d waits", idx, stable, lat);
      else passed++;
    end
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o} !== 4'b0001)
      $display("[TB] FAIL gap_%0d: cyc/stb/we/busy=%b expected 0001",
               idx, {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o});
    else passed++;
    @(negedge clk);
  endtask

  // Full sequence; lat < 0 picks a random wait per write.
  task automatic run_seq(input bit mir, input bit tx, input int lat);
    int n;
    build_model(mir, tx);
    n = exp_adr.size();
    kick(mir, tx);
    for (int i = 0; i < n; i++) begin
      serve_write(i, (lat < 0) ? int'($urandom_range(0, 4)) : lat);
      if (i < n - 1) begin
        total++;
        if ({wbm_stb_o, done_o} !== 2'b10)
          $display("[TB] FAIL cadence_%0d: stb/done=%b expected 10", i, {wbm_stb_o, done_o});
        else passed++;
      end
    end
    total++;
    if ({done_o, busy_o, wbm_stb_o} !== 3'b110)
      $display("[TB] FAIL done_pulse: done/busy/stb=%b expected 110", {done_o, busy_o, wbm_stb_o});
    else passed++;
    @(negedge clk);
    total++;
    if ({done_o, busy_o, err_o, wbm_stb_o} !== 4'b0000)
      $display("[TB] FAIL after_done: done/busy/err/stb=%b expected 0000",
               {done_o, busy_o, err_o, wbm_stb_o});
    else passed++;
  endtask

  task automatic test_reset();
    wb_rst_i  = 1'b1;
    start_i   = 1'b0;
    mir_i     = 1'b0;
    tx_i      = 1'b0;
    wbm_ack_i = 1'b0;
    #3;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, busy_o, done_o, err_o, step_o} !== '0)
      $display("[TB] FAIL reset_outputs: adr=%h dat=%h ctl=%b step=%0d expected all zero",
               wbm_adr_o, wbm_dat_o, {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, done_o, err_o}, step_o);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_outside_req();
    wbm_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    wbm_ack_i = 1'b0;
    total++;
    if ({busy_o, wbm_stb_o, done_o, step_o} !== 6'b000000)
      $display("[TB] FAIL idle_ack: busy/stb/done=%b step=%0d expected 000 step=0",
               {busy_o, wbm_stb_o, done_o}, step_o);
    else passed++;
  endtask

  task automatic test_mir_tx();
    run_seq(1'b1, 1'b1, 0);
  endtask

  task automatic test_sir_rx();
    run_seq(1'b0, 1'b0, 0);
  endtask

  task automatic test_wait_states();
    run_seq(1'b1, 1'b0, 3);
    run_seq(1'b0, 1'b1, 3);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++)
      run_seq(1'($urandom), 1'($urandom), -1);
  endtask

  // Start during a sequence is ignored; reset at step 3 aborts at once.
  task automatic test_back_to_back();
    build_model(1'b0, 1'b0);
    kick(1'b0, 1'b0);
    serve_write(0, 0);
    start_i = 1'b1;
    mir_i   = 1'b1;
    tx_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    serve_write(1, 0);
    serve_write(2, 0);
    total++;
    if ({wbm_stb_o, step_o} !== {1'b1, 3'd3})
      $display("[TB] FAIL at_step3: stb=%b step=%0d expected stb=1 step=3", wbm_stb_o, step_o);
    else passed++;
    #2;
    wb_rst_i = 1'b1;
    #1;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, busy_o, done_o, err_o, step_o} !== '0)
      $display("[TB] FAIL async_abort: adr=%h dat=%h ctl=%b step=%0d expected all zero",
               wbm_adr_o, wbm_dat_o, {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, done_o, err_o}, step_o);
    else passed++;
    @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_o, wbm_stb_o, done_o, step_o} !== 6'b000000)
      $display("[TB] FAIL post_reset: busy/stb/done=%b step=%0d expected 000 step=0",
               {busy_o, wbm_stb_o, done_o}, step_o);
    else passed++;
    run_seq(1'b1, 1'b1, 0);
  endtask

`ifdef IRDA_CFG_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    run_seq(1'b1, 1'b1, 15);
    build_model(1'b1, 1'b0);
    kick(1'b1, 1'b0);
    serve_write(0, 0);
    serve_write(1, 0);
    cnt = 0;
    while (wbm_stb_o === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt !== 16)
      $display("[TB] FAIL timeout_len: strobe cycles=%0d expected 16", cnt);
    else passed++;
    total++;
    if ({err_o, busy_o, done_o, step_o} !== {3'b110, 3'd2})
      $display("[TB] FAIL timeout_err: err/busy/done=%b step=%0d expected 110 step=2",
               {err_o, busy_o, done_o}, step_o);
    else passed++;
    @(negedge clk);
    total++;
    if ({err_o, busy_o, done_o} !== 3'b100)
      $display("[TB] FAIL timeout_idle: err/busy/done=%b expected 100", {err_o, busy_o, done_o});
    else passed++;
    run_seq(1'b1, 1'b0, 0);
  endtask
`else
  task automatic test_no_timeout();
    run_seq(1'b0, 1'b0, 20);
    total++;
    if (err_o !== 1'b0)
      $display("[TB] FAIL no_timeout_err: err=%b expected 0", err_o);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_ack_outside_req();
    test_mir_tx();
    test_sir_rx();
    test_wait_states();
    test_back_to_back();
`ifdef IRDA_CFG_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
